i2s_receiver: RTL and testbench

I2S_RECEIVER -- requirements
Module: i2s_receiver

---
 rtl/audio_pkg.sv | 16 +
 rtl/sync_edge_detect.sv | 32 +++
 rtl/i2s_receiver.sv | 143 ++++++++++++++
 tb/tb_i2s_receiver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: default word width, channel encoding and receiver states.
package audio_pkg;

  localparam int unsigned default_sample_width = 16;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } channel_e;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RECEIVE    = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchronizer for one asynchronous input, with a one-cycle rising-edge strobe.
module sync_edge_detect #(
  parameter int unsigned stages = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [stages-1:0] sync_q;
  logic              level_d;

  // NOTE: sequential state uses <= so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < int'(stages); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      level_d <= sync_q[stages-1];
    end
  end

  assign level = sync_q[stages-1];
  assign rise  = level & ~level_d;

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: oversamples bclk, deserialises left/right words and offers each on a valid/ready stream.
module i2s_receiver
  import audio_pkg::*;
#(
  parameter int unsigned sample_width = default_sample_width,
  parameter int unsigned sync_stages  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_bclk,
  input  logic                    i_lrclk,
  input  logic                    i_data,
  output logic                    o_left_valid,
  input  logic                    o_left_ready,
  output logic [sample_width-1:0] o_left_value,
  output logic                    o_right_valid,
  input  logic                    o_right_ready,
  output logic [sample_width-1:0] o_right_value,
  output logic                    o_overrun
);

  localparam int unsigned count_width = $clog2(sample_width + 1);
  localparam logic [count_width-1:0]  full_count = count_width'(sample_width);
  localparam logic [sample_width-1:0] msb_one    = {1'b1, {(sample_width-1){1'b0}}};

  logic bclk_rise, lrclk_level, data_level;
  logic unused_bclk_level, unused_lrclk_rise, unused_data_rise;

  sync_edge_detect #(.stages(sync_stages)) u_sync_bclk (
    .clk(clk), .reset(reset), .async_in(i_bclk),
    .level(unused_bclk_level), .rise(bclk_rise)
  );

  sync_edge_detect #(.stages(sync_stages)) u_sync_lrclk (
    .clk(clk), .reset(reset), .async_in(i_lrclk),
    .level(lrclk_level), .rise(unused_lrclk_rise)
  );

  sync_edge_detect #(.stages(sync_stages)) u_sync_data (
    .clk(clk), .reset(reset), .async_in(i_data),
    .level(data_level), .rise(unused_data_rise)
  );

  rx_state_e                state;
  channel_e                 prev_ch;
  channel_e                 lr_ch;
  logic                     have_prev;
  logic [sample_width-1:0]  word;
  logic [count_width-1:0]   bit_count;
  logic [sample_width-1:0]  word_appended;
  logic [count_width-1:0]   count_appended;
  logic                     lr_changed;
  logic                     commit;
  logic [1:0]               commit_vec;
  logic [1:0]               ready_vec;

  assign lr_ch      = channel_e'(lrclk_level);
  assign lr_changed = have_prev && (lr_ch != prev_ch);
  assign commit     = bclk_rise && (state == RECEIVE) && lr_changed;
  assign ready_vec  = {o_right_ready, o_left_ready};

  // Bits land MSB-first at their final position, so a short word is already left-justified.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    word_appended  = word;
    count_appended = bit_count;
    commit_vec     = '0;
    if (bit_count < full_count) begin
      word_appended  = word | (data_level ? (msb_one >> bit_count) : '0);
      count_appended = bit_count + 1'b1;
    end
    if (commit) begin
      commit_vec[prev_ch] = 1'b1;
    end
  end

  // The first strobe after reset only records lrclk, so a word already in flight is never framed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= WAIT_FRAME;
      prev_ch   <= LEFT;
      have_prev <= 1'b0;
      word      <= '0;
      bit_count <= '0;
    end else if (bclk_rise) begin
      prev_ch   <= lr_ch;
      have_prev <= 1'b1;
      case (state)
        WAIT_FRAME: begin
          if (lr_changed) begin
            state     <= RECEIVE;
            word      <= '0;
            bit_count <= '0;
          end
        end
        RECEIVE: begin
          if (lr_changed) begin
            word      <= '0;
            bit_count <= '0;
          end else begin
            word      <= word_appended;
            bit_count <= count_appended;
          end
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end

  logic [1:0]              valid_q;
  logic [sample_width-1:0] value_q [2];

  // Per-channel holding register; a commit into a full, stalled register is dropped.
  // NOTE: the value registers are reset too, because the outputs must read 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= '0;
      value_q[0] <= '0;
      value_q[1] <= '0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        if (commit_vec[ch]) begin
          if (!valid_q[ch] || ready_vec[ch]) begin
            value_q[ch] <= word_appended;
            valid_q[ch] <= 1'b1;
          end else begin
            o_overrun <= 1'b1;
          end
        end else if (valid_q[ch] && ready_vec[ch]) begin
          valid_q[ch] <= 1'b0;
        end
      end
    end
  end

  assign o_left_valid  = valid_q[int'(LEFT)];
  assign o_left_value  = value_q[int'(LEFT)];
  assign o_right_valid = valid_q[int'(RIGHT)];
  assign o_right_value = value_q[int'(RIGHT)];

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: framing, truncation, short words, overrun, same-cycle accept, reset recovery.
module tb_i2s_receiver;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_bclk = 1'b0;
  logic         i_lrclk = 1'b1;
  logic         i_data = 1'b0;
  logic         left_ready = 1'b1;
  logic         right_ready = 1'b1;
  logic         o_left_valid, o_right_valid, o_overrun;
  logic [W-1:0] o_left_value, o_right_value;

  logic         carry = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  logic [W-1:0] left_q[$];
  logic [W-1:0] right_q[$];
  int           left_valid_cycles = 0;
  int           right_valid_cycles = 0;
  int           overrun_cycles = 0;

  always #5 clk = ~clk;

  i2s_receiver #(.sample_width(W), .sync_stages(2)) dut (
    .clk(clk),
    .reset(reset),
    .i_bclk(i_bclk),
    .i_lrclk(i_lrclk),
    .i_data(i_data),
    .o_left_valid(o_left_valid),
    .o_left_ready(left_ready),
    .o_left_value(o_left_value),
    .o_right_valid(o_right_valid),
    .o_right_ready(right_ready),
    .o_right_value(o_right_value),
    .o_overrun(o_overrun)
  );

  // Handshake recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_left_valid) left_valid_cycles++;
    if (o_right_valid) right_valid_cycles++;
    if (o_left_valid && left_ready) left_q.push_back(o_left_value);
    if (o_right_valid && right_ready) right_q.push_back(o_right_value);
    if (o_overrun) overrun_cycles++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [W-1:0] q_at(input logic [W-1:0] q[$], input int k);
    return (k < q.size()) ? q[k] : 'x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic lr, input logic d);
    i_bclk = 1'b0; i_lrclk = lr; i_data = d;
    tick(4);
    i_bclk = 1'b1;
    tick(4);
  endtask

  // One I2S slot: first bit is the previous word's LSB, then this word MSB..bit1.
  task automatic send_slot(input logic lr, input logic [31:0] word, input int n);
    send_bit(lr, carry);
    for (int i = n - 1; i >= 1; i--) send_bit(lr, word[i]);
    carry = word[0];
  endtask

  task automatic clear_scoreboard();
    left_q.delete();
    right_q.delete();
    left_valid_cycles = 0;
    right_valid_cycles = 0;
    overrun_cycles = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b0; i_bclk = 1'b0; i_lrclk = 1'b1; i_data = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);
    carry = 1'b0;
    clear_scoreboard();
  endtask

  task automatic prime();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_left_valid", o_left_valid, 0);
    check("rst_left_value", o_left_value, 0);
    check("rst_right_valid", o_right_valid, 0);
    check("rst_right_value", o_right_value, 0);
    check("rst_overrun", o_overrun, 0);

    // Mid-word start, then full frames with ready held high
    apply_reset();
    send_slot(1'b1, 32'h7F, 7);
    send_slot(1'b0, 32'h1234, 16);
    check("midword_no_left", left_q.size(), 0);
    check("midword_no_right", right_q.size(), 0);
    send_slot(1'b1, 32'h5A5A, 16);
    check("first_left_1234", q_at(left_q, 0), 16'h1234);
    check("first_left_one_cycle", left_valid_cycles, 1);
    send_slot(1'b0, 32'h8001, 16);
    check("right_5a5a", q_at(right_q, 0), 16'h5A5A);
    check("right_count_1", right_q.size(), 1);
    send_slot(1'b1, 32'h7FFE, 16);
    check("left_8001", q_at(left_q, 1), 16'h8001);
    check("left_valid_cycles_2", left_valid_cycles, 2);
    send_slot(1'b0, 32'h0, 16);
    check("right_7ffe", q_at(right_q, 1), 16'h7FFE);
    check("right_valid_cycles_2", right_valid_cycles, 2);
    check("frame_no_overrun", overrun_cycles, 0);
    check("left_valid_cleared", o_left_valid, 0);

    // 24-bit words truncate, 12-bit words left-justify
    apply_reset();
    prime();
    send_slot(1'b0, 32'hABCDEF, 24);
    send_slot(1'b1, 32'h0, 24);
    check("trunc_24_left", q_at(left_q, 0), 16'hABCD);
    send_slot(1'b0, 32'hFFF, 12);
    check("trunc_24_right_zero", q_at(right_q, 0), 16'h0000);
    send_slot(1'b1, 32'h0, 12);
    check("short_12_left", q_at(left_q, 1), 16'hFFF0);

    // Overrun: left stalled across two words
    apply_reset();
    prime();
    left_ready = 1'b0;
    send_slot(1'b0, 32'h1111, 16);
    send_slot(1'b1, 32'h0, 16);
    check("stall_valid", o_left_valid, 1);
    check("stall_value", o_left_value, 16'h1111);
    send_slot(1'b0, 32'h2222, 16);
    send_slot(1'b1, 32'h0, 16);
    check("overrun_value_held", o_left_value, 16'h1111);
    check("overrun_once", overrun_cycles, 1);
    check("overrun_nothing_accepted", left_q.size(), 0);
    left_ready = 1'b1;
    tick(1);
    check("overrun_accept_1111", q_at(left_q, 0), 16'h1111);
    check("overrun_accept_count", left_q.size(), 1);
    check("overrun_valid_cleared", o_left_valid, 0);

    // Ready rises in the cycle a new left commit lands
    apply_reset();
    prime();
    left_ready = 1'b0;
    send_slot(1'b0, 32'hAAAA, 16);
    send_slot(1'b1, 32'h0, 16);
    send_slot(1'b0, 32'h5555, 16);
    i_bclk = 1'b0; i_lrclk = 1'b1; i_data = carry;
    tick(4);
    i_bclk = 1'b1;
    tick(2);
    left_ready = 1'b1;
    tick(1);
    check("same_cycle_old_accepted", q_at(left_q, 0), 16'hAAAA);
    check("same_cycle_new_value", o_left_value, 16'h5555);
    check("same_cycle_valid_high", o_left_valid, 1);
    check("same_cycle_no_overrun", overrun_cycles, 0);
    tick(1);
    check("same_cycle_new_accepted", q_at(left_q, 1), 16'h5555);
    check("same_cycle_valid_cleared", o_left_valid, 0);

    // Reset mid-right-word, then recovery
    apply_reset();
    prime();
    left_ready = 1'b0;
    send_slot(1'b0, 32'h1357, 16);
    send_bit(1'b1, carry);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    check("pre_reset_left_valid", o_left_valid, 1);
    reset = 1'b0;
    #2;
    check("async_rst_left_valid", o_left_valid, 0);
    check("async_rst_left_value", o_left_value, 0);
    check("async_rst_right_valid", o_right_valid, 0);
    check("async_rst_right_value", o_right_value, 0);
    check("async_rst_overrun", o_overrun, 0);
    tick(2);
    reset = 1'b1;
    left_ready = 1'b1;
    clear_scoreboard();
    repeat (5) send_bit(1'b1, 1'b1);
    send_slot(1'b0, 32'h9ABC, 16);
    send_slot(1'b1, 32'h0, 16);
    check("recover_no_right", right_q.size(), 0);
    check("recover_left_9abc", q_at(left_q, 0), 16'h9ABC);
    check("recover_left_count", left_q.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
